// File: rtl/inst_mem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset meanwhile.
module inst_mem_loader #(
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic                  i_in_valid,
   input  logic [7:0]            i_in_data,
   input  logic                  i_in_last,
   output logic                  o_in_ready,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [31:0]           o_mem_wdata,
   output logic                  o_core_reset,
   output logic                  o_load_done,
   output logic                  o_load_error,
   output logic [ADDR_WIDTH:0]   o_word_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_WIDTH:0] LP_FULL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH + 1)'(1);

   state_t                r_state;
   logic [1:0]            r_idx;
   logic [23:0]           r_asm;
   logic                  r_ready;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wdata;
   logic                  r_core_reset;
   logic                  r_done;
   logic                  r_err;
   logic [ADDR_WIDTH:0]   r_wc;

   logic                  w_accept;

   // A byte moves only when the stream offers it and the loader is in LOAD.
   assign w_accept = i_in_valid && r_ready;

   // Loader FSM; every output is a register updated here.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_idx        <= 2'd0;
         r_asm        <= 24'd0;
         r_ready      <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= 32'd0;
         r_core_reset <= 1'b1;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_wc         <= '0;
      end else begin
         r_mem_we <= 1'b0;
         unique case (r_state)
            S_IDLE, S_ERROR: begin
               if (i_start) begin
                  r_state <= S_LOAD;
                  r_ready <= 1'b1;
                  r_idx   <= 2'd0;
                  r_wc    <= '0;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            S_DONE: begin
               if (i_start) begin
                  r_state      <= S_LOAD;
                  r_ready      <= 1'b1;
                  r_idx        <= 2'd0;
                  r_wc         <= '0;
                  r_done       <= 1'b0;
                  r_err        <= 1'b0;
                  r_core_reset <= 1'b1;
               end else begin
                  // one cycle after entry, so the last write has landed
                  r_core_reset <= 1'b0;
                  r_done       <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  if (r_wc == LP_FULL) begin
                     r_state <= S_ERROR;
                     r_ready <= 1'b0;
                     r_err   <= 1'b1;
                  end else if (r_idx == 2'd3) begin
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_wc[ADDR_WIDTH-1:0];
                     r_mem_wdata <= {i_in_data, r_asm};
                     r_wc        <= r_wc + LP_ONE;
                     r_idx       <= 2'd0;
                     if (i_in_last) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b0;
                     end
                  end else if (i_in_last) begin
                     r_state <= S_ERROR;
                     r_ready <= 1'b0;
                     r_err   <= 1'b1;
                  end else begin
                     r_asm[{r_idx, 3'b000} +: 8] <= i_in_data;
                     r_idx <= r_idx + 2'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_in_ready   = r_ready;
   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_core_reset = r_core_reset;
   assign o_load_done  = r_done;
   assign o_load_error = r_err;
   assign o_word_count = r_wc;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two instances (DEPTH 64 and 4) share one
// stimulus stream and are checked every cycle against a byte-count model.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        vld = 1'b0;
   logic [7:0]  data = 8'd0;
   logic        last = 1'b0;

   logic        a_rdy, a_we, a_cr, a_dn, a_er;
   logic [5:0]  a_addr;
   logic [31:0] a_wd;
   logic [6:0]  a_wc;
   logic        b_rdy, b_we, b_cr, b_dn, b_er;
   logic [1:0]  b_addr;
   logic [31:0] b_wd;
   logic [2:0]  b_wc;

   inst_mem_loader #(.DEPTH(64), .ADDR_WIDTH(6)) dut_a (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
      .i_in_valid(vld), .i_in_data(data), .i_in_last(last),
      .o_in_ready(a_rdy), .o_mem_we(a_we), .o_mem_addr(a_addr),
      .o_mem_wdata(a_wd), .o_core_reset(a_cr), .o_load_done(a_dn),
      .o_load_error(a_er), .o_word_count(a_wc)
   );

   inst_mem_loader #(.DEPTH(4), .ADDR_WIDTH(2)) dut_b (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start),
      .i_in_valid(vld), .i_in_data(data), .i_in_last(last),
      .o_in_ready(b_rdy), .o_mem_we(b_we), .o_mem_addr(b_addr),
      .o_mem_wdata(b_wd), .o_core_reset(b_cr), .o_load_done(b_dn),
      .o_load_error(b_er), .o_word_count(b_wc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

   int          m_mode [2];
   int          m_n    [2];
   int          m_depth[2];
   logic [7:0]  m_buf  [2][4];
   logic        e_rdy[2], e_we[2], e_cr[2], e_dn[2], e_er[2];
   logic [31:0] e_addr[2], e_wd[2], e_wc[2];

   typedef struct {
      logic s, v;
      logic [7:0] d;
      logic l;
      logic rdy, we;
      logic [5:0] addr;
      logic [31:0] wd;
      logic cr, dn, er;
      logic [6:0] wc;
   } vec_t;

   vec_t tbl[11];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = M_IDLE; m_n[k] = 0;
         e_rdy[k] = 0; e_we[k] = 0; e_addr[k] = 0; e_wd[k] = 0;
         e_cr[k] = 1; e_dn[k] = 0; e_er[k] = 0; e_wc[k] = 0;
      end
   endtask

   task automatic begin_load(int k);
      m_mode[k] = M_LOAD; m_n[k] = 0; e_wc[k] = 0;
      e_dn[k] = 0; e_er[k] = 0; e_rdy[k] = 1;
   endtask

   // Model: a load is the count of bytes taken; word = n/4, lane = n%4.
   task automatic model_edge(int k);
      int pos, words;
      e_we[k] = 0;
      case (m_mode[k])
         M_IDLE, M_ERR: if (start) begin_load(k);
         M_DONE: begin
            if (start) begin
               begin_load(k); e_cr[k] = 1;
            end else begin
               e_cr[k] = 0; e_dn[k] = 1;
            end
         end
         default: begin
            if (vld) begin
               pos = m_n[k] % 4;
               words = m_n[k] / 4;
               if (words == m_depth[k]) begin
                  m_mode[k] = M_ERR; e_rdy[k] = 0; e_er[k] = 1;
               end else begin
                  m_buf[k][pos] = data;
                  if (pos == 3) begin
                     e_we[k] = 1;
                     e_addr[k] = words;
                     e_wd[k] = {m_buf[k][3], m_buf[k][2], m_buf[k][1], m_buf[k][0]};
                     m_n[k] = m_n[k] + 1;
                     e_wc[k] = m_n[k] / 4;
                     if (last) begin
                        m_mode[k] = M_DONE; e_rdy[k] = 0;
                     end
                  end else if (last) begin
                     m_mode[k] = M_ERR; e_rdy[k] = 0; e_er[k] = 1;
                  end else begin
                     m_n[k] = m_n[k] + 1;
                  end
               end
            end
         end
      endcase
   endtask

   task automatic chk(int k, string tag);
      logic [31:0] g_addr, g_wd, g_wc;
      logic [4:0] g_b, w_b;
      if (k == 0) begin
         g_b = {a_rdy, a_we, a_cr, a_dn, a_er};
         g_addr = 32'(a_addr); g_wd = a_wd; g_wc = 32'(a_wc);
      end else begin
         g_b = {b_rdy, b_we, b_cr, b_dn, b_er};
         g_addr = 32'(b_addr); g_wd = b_wd; g_wc = 32'(b_wc);
      end
      w_b = {e_rdy[k], e_we[k], e_cr[k], e_dn[k], e_er[k]};
      n_tests++;
      if (g_b !== w_b || g_addr !== e_addr[k] || g_wd !== e_wd[k] || g_wc !== e_wc[k]) begin
         n_fail++;
         $display("FAIL %s dut%0d: got rdy/we/cr/dn/er=%b addr=%0d wd=%h wc=%0d, want %b addr=%0d wd=%h wc=%0d",
                  tag, k, g_b, g_addr, g_wd, g_wc, w_b, e_addr[k], e_wd[k], e_wc[k]);
      end
   endtask

   task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(logic s, logic v, logic [7:0] d, logic l, string tag);
      start = s; vld = v; data = d; last = l;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      chk(0, tag);
      chk(1, tag);
   endtask

   task automatic rst_pulse(string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk(0, {tag, "_async"});
      chk(1, {tag, "_async"});
      @(posedge clk);
      #1;
      chk(0, {tag, "_held"});
      chk(1, {tag, "_held"});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(logic [7:0] b[], bit with_last, int max_gap, string tag);
      for (int i = 0; i < b.size(); i++) begin
         int g;
         g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         for (int j = 0; j < g; j++)
            step(1'b0, 1'b0, 8'($urandom), 1'($urandom), {tag, "_gap"});
         step(1'b0, 1'b1, b[i], with_last && (i == b.size() - 1), tag);
      end
   endtask

   logic [7:0] prog[]  = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
   logic [7:0] six[]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   logic [7:0] ovf[];
   logic [7:0] tail[]  = '{8'hA1, 8'hA2, 8'hA3};
   logic [7:0] two[]   = '{8'hDE, 8'hAD};

   initial begin
      m_depth[0] = 64;
      m_depth[1] = 4;
      model_reset();

      tbl[0]  = '{1,1,8'hFF,0, 1,0,6'd0,32'h0,        1,0,0,7'd0};
      tbl[1]  = '{0,1,8'h13,0, 1,0,6'd0,32'h0,        1,0,0,7'd0};
      tbl[2]  = '{0,1,8'h00,0, 1,0,6'd0,32'h0,        1,0,0,7'd0};
      tbl[3]  = '{0,1,8'h50,0, 1,0,6'd0,32'h0,        1,0,0,7'd0};
      tbl[4]  = '{0,1,8'h00,0, 1,1,6'd0,32'h00500013, 1,0,0,7'd1};
      tbl[5]  = '{0,1,8'h93,0, 1,0,6'd0,32'h00500013, 1,0,0,7'd1};
      tbl[6]  = '{0,1,8'h00,0, 1,0,6'd0,32'h00500013, 1,0,0,7'd1};
      tbl[7]  = '{0,1,8'h10,0, 1,0,6'd0,32'h00500013, 1,0,0,7'd1};
      tbl[8]  = '{0,1,8'h00,1, 0,1,6'd1,32'h00100093, 1,0,0,7'd2};
      tbl[9]  = '{0,0,8'h00,0, 0,0,6'd1,32'h00100093, 0,1,0,7'd2};
      tbl[10] = '{0,0,8'h00,0, 0,0,6'd1,32'h00100093, 0,1,0,7'd2};

      // reset held, with start and a byte offered
      #1 rst_n = 1'b0;
      start = 1'b1; vld = 1'b1; data = 8'h5A;
      @(negedge clk);
      chk(0, "reset_hold");
      chk(1, "reset_hold");
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 8'h77, 1'b0, "idle_byte");
      step(1'b0, 1'b0, 8'h00, 1'b0, "idle");

      // basic load from the vector table
      for (int i = 0; i < 11; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l, tag);
         n_tests++;
         if ({a_rdy, a_we, a_addr, a_wd, a_cr, a_dn, a_er, a_wc} !==
             {tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd,
              tbl[i].cr, tbl[i].dn, tbl[i].er, tbl[i].wc}) begin
            n_fail++;
            $display("FAIL %s_tbl: got we=%b addr=%0d wd=%h cr=%b dn=%b wc=%0d, want we=%b addr=%0d wd=%h cr=%b dn=%b wc=%0d",
                     tag, a_we, a_addr, a_wd, a_cr, a_dn, a_wc,
                     tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].cr, tbl[i].dn, tbl[i].wc);
         end
      end

      // same program with random idle gaps
      step(1'b1, 1'b0, 8'h00, 1'b0, "gap_start");
      send(prog, 1, 3, "gap");
      step(1'b0, 1'b0, 8'h00, 1'b0, "gap_tail");
      expect_eq("gap_done", {a_dn, a_cr}, 32'b10);
      expect_eq("gap_wc", 32'(a_wc), 32'd2);

      // short last word
      step(1'b1, 1'b0, 8'h00, 1'b0, "short_start");
      send(six, 1, 1, "short");
      step(1'b0, 1'b0, 8'h00, 1'b0, "short_tail");
      expect_eq("short_err", {a_er, a_cr, a_dn}, 32'b110);
      expect_eq("short_wc", 32'(a_wc), 32'd1);

      // overflow on the DEPTH=4 instance, then finish the big one
      ovf = new[17];
      foreach (ovf[i]) ovf[i] = 8'(i * 7 + 3);
      step(1'b1, 1'b0, 8'h00, 1'b0, "ovf_start");
      send(ovf, 0, 0, "ovf");
      expect_eq("ovf_err_b", {b_er, b_rdy, b_cr}, 32'b101);
      expect_eq("ovf_wc_b", 32'(b_wc), 32'd4);
      expect_eq("ovf_a_busy", {a_er, a_rdy}, 32'b01);
      send(tail, 1, 0, "ovf_tail");
      step(1'b0, 1'b0, 8'h00, 1'b0, "ovf_idle");
      expect_eq("ovf_wc_a", 32'(a_wc), 32'd5);

      // reload from DONE, then reset mid-load
      step(1'b1, 1'b0, 8'h00, 1'b0, "rl_start");
      send(prog, 1, 0, "rl");
      step(1'b0, 1'b0, 8'h00, 1'b0, "rl_w");
      step(1'b0, 1'b0, 8'h00, 1'b0, "rl_w2");
      expect_eq("rl_running", {a_cr, a_dn}, 32'b01);
      step(1'b1, 1'b1, 8'h99, 1'b0, "rl_restart");
      expect_eq("rl_core_rst", {a_cr, a_dn, a_rdy}, 32'b101);
      send(two, 0, 0, "mid");
      rst_pulse("mid_rst");
      step(1'b0, 1'b0, 8'h00, 1'b0, "post_rst");

      // random loads against the model
      for (int it = 0; it < 14; it++) begin
         int len;
         len = $urandom_range(1, 22);
         step(1'b1, 1'($urandom), 8'($urandom), 1'b0, "rnd_start");
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0)
               step(1'b0, 1'b0, 8'($urandom), 1'($urandom), "rnd_gap");
            step(1'($urandom_range(0, 9) == 0), 1'b1, 8'($urandom),
                 (i == len - 1) && ($urandom_range(0, 7) != 0), "rnd");
         end
         step(1'b0, 1'b0, 8'h00, 1'b0, "rnd_idle");
         step(1'b0, 1'b0, 8'h00, 1'b0, "rnd_idle");
         if ($urandom_range(0, 4) == 0) rst_pulse("rnd_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Boot-time program loader sitting directly upstream of the processor core. It accepts a byte stream on a valid/ready interface and assembles little-endian 32-bit instruction words. It writes those words into instruction memory from word address 0 upward, holding the core in reset until a complete program has been loaded. It replaces hard-coded instruction-memory initialisation, so benches and boards can load programs at run time.

## Interface
- DEPTH, 64: instruction memory size in 32-bit words (power of two, ≥ 2)
- ADDR_WIDTH, 6: log2(DEPTH); width of mem_addr
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: begin a new load
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_last  in  1  marks final byte of program (qualified by in_valid)
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable (one-cycle pulse)
- mem_addr  out  ADDR_WIDTH  word address for the write
- mem_wdata  out  32  word to write
- core_reset  out  1  active-high reset to processor core
- load_done  out  1  program loaded, core running
- load_error  out  1  load aborted
- word_count  out  ADDR_WIDTH+1  words written in current/last load

## Operation
- States: IDLE, LOAD, DONE, ERROR.
- A byte is accepted when in_valid && in_ready. in_ready is 1 only in LOAD.
- **IDLE:**
  - core_reset = 1.
  - start → LOAD; clears byte index, word_count, load_done, load_error.
- **LOAD:**
  - Accepted byte k (k = 0..3) goes into bits [8k+7:8k] of the assembly register.
  - Accepting byte 3 issues a write to address word_count, then increments word_count.
  - Byte 3 with in_last → DONE.
  - in_last on byte 0..2 → ERROR; the partial word is not written.
  - A byte accepted when word_count == DEPTH → ERROR; no write occurs.
  - start is ignored.
- **DONE:**
  - core_reset = 0, load_done = 1.
  - start → LOAD; core_reset reasserts on the same edge and load_done clears.
- **ERROR:**
  - load_error = 1, core_reset stays 1.
  - start → LOAD (clears load_error).
- in_valid/in_data/in_last are ignored outside LOAD.
- When a start pulse and a byte arrive in the same cycle in IDLE, DONE or ERROR, the byte is not accepted, because in_ready is 0 that cycle.

## Timing
- Reset (asynchronous, reset = 0) forces:
  - state IDLE, core_reset = 1, in_ready = 0;
  - mem_we = 0, mem_addr = 0, mem_wdata = 0;
  - load_done = 0, load_error = 0, word_count = 0.
- in_ready is registered. It rises on the edge that enters LOAD and falls on the edge that leaves LOAD.
- Write pipeline: byte 3 is accepted at edge E.
  - After E: mem_we = 1, mem_addr = old word_count, mem_wdata = assembled word, word_count incremented.
  - After E+1: mem_we = 0. mem_addr and mem_wdata hold their values.
- Final word (in_last at edge E):
  - state → DONE and in_ready → 0 at E.
  - core_reset → 0 and load_done → 1 at E+1, so the last write completes before the core leaves reset.
- Error: in_ready → 0 and load_error → 1 at the edge that accepts the offending byte.
- Throughput: one byte per cycle sustained. The write pulse never stalls the stream.
- Reset asserted mid-load: immediate return to reset values. Any partially assembled word is discarded and no write is issued.

## Test plan
- **Reset values:** hold reset low.
  - All outputs at reset values, core_reset = 1.
  - Release reset: stays IDLE, in_ready = 0.
- **Basic load:**
  - Stimulus: start, then bytes 13 00 50 00 / 93 00 10 00 (last), one per cycle.
  - Required writes: mem_we pulses to addr 0 with 0x00500013, then to addr 1 with 0x00100093.
  - word_count = 2. core_reset falls one cycle after the second write, with load_done = 1.
- **Back-pressure-free gaps:** the same stream with in_valid deasserted for random cycles between bytes → identical writes and data.
- **Short last word:** start, 6 bytes with in_last on byte 6.
  - One write only (addr 0), then load_error = 1, core_reset = 1, word_count = 1.
- **Overflow:** DEPTH=4; send 17 bytes, no in_last.
  - 4 writes (addr 0..3), then load_error = 1 on byte 17, with no fifth write.
- **Reload and mid-load reset:**
  - From DONE, start → core_reset = 1 on the next edge.
  - Drive 2 bytes then pulse reset low → no mem_we, all outputs at reset values, state IDLE.
